// File: rtl/writeback_cycle.sv
// Writeback stage: selects the retiring result, owns the integer register file
// (two bypassed decode read ports), and counts retired instructions.
module writeback_cycle #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteW,
  input  logic                 ResultSrcW,
  input  logic                 ValidW,
  input  logic [XLEN-1:0]      ALUResultW,
  input  logic [XLEN-1:0]      ReadDataW,
  input  logic [4:0]           RDW,
  input  logic [4:0]           A1D,
  input  logic [4:0]           A2D,
  output logic [XLEN-1:0]      RD1D,
  output logic [XLEN-1:0]      RD2D,
  output logic [XLEN-1:0]      ResultW,
  output logic [INSTRET_W-1:0] InstretW
);

  logic [XLEN-1:0]      regs_q [NREG];
  logic [INSTRET_W-1:0] instret_q;
  logic [INSTRET_W-1:0] instret_d;
  logic                 we;

  always_comb begin
    ResultW = ResultSrcW ? ReadDataW : ALUResultW;
  end

  always_comb begin
    we = RegWriteW & ValidW & (RDW != '0);
  end

  // x0 slot is cleared on reset but never read: the read ports force zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[RDW] <= ResultW;
    end
  end

  // Bypass gives write-before-read visibility within the writing cycle.
  always_comb begin
    if (A1D == '0) begin
      RD1D = '0;
    end else if (we && (RDW == A1D)) begin
      RD1D = ResultW;
    end else begin
      RD1D = regs_q[A1D];
    end
  end

  always_comb begin
    if (A2D == '0) begin
      RD2D = '0;
    end else if (we && (RDW == A2D)) begin
      RD2D = ResultW;
    end else begin
      RD2D = regs_q[A2D];
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (ValidW) begin
      instret_d = instret_q + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  always_comb begin
    InstretW = instret_q;
  end

endmodule
